// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC owner, 1-cycle registered imem read, FIFO_DEPTH-entry prefetch buffer to decode.
// First word valid 2 cycles after reset release; issue throttles on buffer occupancy, decode stalls hold the head.

module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_wr;

  assign do_pop = rd_rdy & (count != '0);
  assign do_wr  = wr_vld & ((count != DEPTH_C) | do_pop);
  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];

  // Flush only rewinds pointers; stale storage is hidden by rd_vld.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module instr_fetch_unit #(
  parameter int                    PC_WIDTH    = 16,
  parameter int                    INSTR_WIDTH = 16,
  parameter int                    PC_STEP     = 2,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = 16'h0000,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD  = 16'hEFFF,
  parameter int                    FIFO_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    pc_out,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    instr_pc_out,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   halted
);
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [CW+1:0] DEPTH_C = FIFO_DEPTH[CW+1:0];

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } fetch_ent_t;

  typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                inflight;
  fetch_ent_t          push_ent;
  fetch_ent_t          head_ent;
  logic [CW:0]         count;
  logic [CW+1:0]       occupancy;
  logic                redirect_act;
  logic                push;
  logic                halt_push;
  logic                pop;
  logic                issue;

  assign redirect_act = redirect_valid & (state != HALTED);
  assign push         = inflight & ~redirect_act;
  assign halt_push    = push & (imem_data == HALT_WORD);
  assign pop          = instr_valid & instr_ready & ~redirect_act;
  assign push_ent     = '{instr: imem_data, pc: inflight_pc};

  // Counts the word returning this cycle so the buffer can never overflow.
  assign occupancy = {1'b0, count} + {{(CW+1){1'b0}}, inflight}
                   - {{(CW+1){1'b0}}, instr_valid & instr_ready};

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      FETCH: begin
        issue = ~redirect_act & ~halt_push & (occupancy < DEPTH_C);
        if (halt_push) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (redirect_act) state_nxt = FETCH;
        else if (pop && head_ent.instr == HALT_WORD) state_nxt = HALTED;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (redirect_act) begin
        fetch_pc <= {redirect_pc[PC_WIDTH-1:1], 1'b0};
      end else if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + PC_WIDTH'(PC_STEP);
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_ent_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (redirect_act),
    .wr_vld (push),
    .wr_dat (push_ent),
    .rd_rdy (instr_ready & ~redirect_act),
    .rd_vld (instr_valid),
    .rd_dat (head_ent),
    .count  (count)
  );

  assign pc_out       = fetch_pc;
  assign instr_out    = head_ent.instr;
  assign instr_pc_out = head_ent.pc;
  assign halted       = (state == HALTED);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed timing scenarios plus a randomized stream scoreboard.
// Memory model returns 16'h1000|addr (optionally HALT at one address) one cycle after the address.

module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_out;
  logic [15:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] instr_out;
  logic [15:0] instr_pc_out;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        halted;

  logic [15:0] addr_q;
  logic        halt_en = 1'b0;
  logic [15:0] halt_addr = 16'h0008;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pc_out         (pc_out),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_out      (instr_out),
    .instr_pc_out   (instr_pc_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Registered-read instruction memory
  always @(posedge clk) addr_q <= pc_out;
  assign imem_data = (halt_en && addr_q == halt_addr) ? 16'hEFFF : (16'h1000 | addr_q);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leaves the bench at the negedge of cycle 0 after reset release.
  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    n_checks++; if (instr_out !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h want 0000", instr_out); end
    n_checks++; if (instr_pc_out !== 16'h0000) begin n_fail++; $display("FAIL reset_instr_pc got %h want 0000", instr_pc_out); end
    n_checks++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL reset_pc_out got %h want 0000", pc_out); end
    redirect_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_stream();
    logic [15:0] e;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      e = 16'(2 * c);
      n_checks++; if (pc_out !== e) begin n_fail++; $display("FAIL stream_pc_out cyc %0d got %h want %h", c, pc_out, e); end
      n_checks++; if (instr_valid !== (c >= 2)) begin n_fail++; $display("FAIL stream_valid cyc %0d got %b want %b", c, instr_valid, c >= 2); end
      if (c >= 2) begin
        e = 16'(2 * (c - 2));
        n_checks++; if (instr_pc_out !== e) begin n_fail++; $display("FAIL stream_ipc cyc %0d got %h want %h", c, instr_pc_out, e); end
        n_checks++; if (instr_out !== (16'h1000 | e)) begin n_fail++; $display("FAIL stream_data cyc %0d got %h want %h", c, instr_out, 16'h1000 | e); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_pc;
    int pops;
    exp_pc = '0;
    pops = 0;
    do_reset();
    for (int c = 0; c < 40 && pops < 6; c++) begin
      instr_ready = !(c >= 2 && c <= 6);
      if (!instr_ready) begin
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b want 1", c, instr_valid); end
        n_checks++; if (instr_out !== 16'h1000) begin n_fail++; $display("FAIL bp_hold_data cyc %0d got %h want 1000", c, instr_out); end
        n_checks++; if (instr_pc_out !== 16'h0000) begin n_fail++; $display("FAIL bp_hold_pc cyc %0d got %h want 0000", c, instr_pc_out); end
        n_checks++; if (pc_out !== 16'h0004) begin n_fail++; $display("FAIL bp_pc_out cyc %0d got %h want 0004", c, pc_out); end
      end
      if (instr_valid && instr_ready) begin
        n_checks++; if (instr_pc_out !== exp_pc || instr_out !== (16'h1000 | exp_pc)) begin
          n_fail++; $display("FAIL bp_order cyc %0d got %h@%h want %h@%h", c, instr_out, instr_pc_out, 16'h1000 | exp_pc, exp_pc);
        end
        exp_pc += 16'd2;
        pops++;
      end
      @(negedge clk);
    end
    n_checks++; if (pops != 6) begin n_fail++; $display("FAIL bp_pop_count got %0d want 6", pops); end
    instr_ready = 1'b1;
  endtask

  task automatic test_redirect();
    do_reset();
    instr_ready = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rd_full_valid got %b want 1", instr_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 16'h0031;
    instr_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flush_valid got %b want 0", instr_valid); end
    n_checks++; if (pc_out !== 16'h0030) begin n_fail++; $display("FAIL rd_pc_out got %h want 0030", pc_out); end
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rd_gap_valid got %b want 0", instr_valid); end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (instr_valid !== 1'b1 || instr_pc_out !== 16'(16'h0030 + 2 * k) || instr_out !== (16'h1000 | 16'(16'h0030 + 2 * k))) begin
        n_fail++; $display("FAIL rd_stream k %0d got v%b %h@%h want %h@%h", k, instr_valid, instr_out, instr_pc_out,
                           16'h1000 | 16'(16'h0030 + 2 * k), 16'(16'h0030 + 2 * k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt();
    logic [15:0] exp_pc;
    bit halt_popped;
    exp_pc = '0;
    halt_popped = 1'b0;
    halt_en = 1'b1;
    halt_addr = 16'h0008;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      redirect_valid = (c == 10);
      redirect_pc = 16'h0040;
      n_checks++; if (halted !== halt_popped) begin n_fail++; $display("FAIL halt_flag cyc %0d got %b want %b", c, halted, halt_popped); end
      if (c >= 5) begin
        n_checks++; if (pc_out !== 16'(halt_addr + 16'd2)) begin n_fail++; $display("FAIL halt_pc_stop cyc %0d got %h want %h", c, pc_out, 16'(halt_addr + 16'd2)); end
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
        n_checks++; if (instr_pc_out !== exp_pc || instr_out !== ((exp_pc == halt_addr) ? 16'hEFFF : (16'h1000 | exp_pc))) begin
          n_fail++; $display("FAIL halt_word cyc %0d got %h@%h want pc %h", c, instr_out, instr_pc_out, exp_pc);
        end
        if (instr_out == 16'hEFFF) halt_popped = 1'b1;
        exp_pc += 16'd2;
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    n_checks++; if (exp_pc !== 16'(halt_addr + 16'd2)) begin n_fail++; $display("FAIL halt_delivered next %h want %h", exp_pc, 16'(halt_addr + 16'd2)); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky got %b want 1", halted); end
    halt_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_reset_clear got %b want 0", halted); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc;
    int post;
    exp_pc = '0;
    post = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      redirect_valid = (c == 3);
      redirect_pc = 16'hFFFE;
      if (c == 4) begin
        n_checks++; if (pc_out !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_pc_a got %h want fffe", pc_out); end
      end
      if (c == 5) begin
        n_checks++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc_b got %h want 0000", pc_out); end
      end
      if (redirect_valid) begin
        exp_pc = 16'hFFFE;
        post = 0;
      end else if (instr_valid && instr_ready) begin
        n_checks++; if (instr_pc_out !== exp_pc || instr_out !== (16'h1000 | exp_pc)) begin
          n_fail++; $display("FAIL wrap_word cyc %0d got %h@%h want %h@%h", c, instr_out, instr_pc_out, 16'h1000 | exp_pc, exp_pc);
        end
        exp_pc += 16'd2;
        post++;
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    n_checks++; if (post < 3) begin n_fail++; $display("FAIL wrap_count got %0d want >=3", post); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", instr_valid); end
    n_checks++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_pc got %h want 0000", pc_out); end
    n_checks++; if (instr_out !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_instr got %h want 0000", instr_out); end
    repeat (2) @(negedge clk);
    n_checks++; if (instr_valid !== 1'b1 || instr_pc_out !== 16'h0000 || instr_out !== 16'h1000) begin
      n_fail++; $display("FAIL mid_rst_first got v%b %h@%h want 1000@0000", instr_valid, instr_out, instr_pc_out);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] hold_dat;
    logic [15:0] hold_pc;
    bit hold_pending;
    bit after_redirect;
    bit rv;
    int idle;
    exp_pc = '0;
    hold_dat = '0;
    hold_pc = '0;
    hold_pending = 1'b0;
    after_redirect = 1'b0;
    idle = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 29) == 0);
      redirect_valid = rv;
      redirect_pc = 16'($urandom);
      if (after_redirect) begin
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush cyc %0d valid %b want 0", c, instr_valid); end
      end
      if (hold_pending) begin
        n_checks++; if (instr_valid !== 1'b1 || instr_out !== hold_dat || instr_pc_out !== hold_pc) begin
          n_fail++; $display("FAIL rnd_hold cyc %0d got v%b %h@%h want %h@%h", c, instr_valid, instr_out, instr_pc_out, hold_dat, hold_pc);
        end
      end
      if (!rv && instr_valid && instr_ready) begin
        n_checks++; if (instr_pc_out !== exp_pc || instr_out !== (16'h1000 | exp_pc)) begin
          n_fail++; $display("FAIL rnd_order cyc %0d got %h@%h want %h@%h", c, instr_out, instr_pc_out, 16'h1000 | exp_pc, exp_pc);
        end
        exp_pc += 16'd2;
      end
      if (rv) idle = 0;
      else if (!instr_valid) idle++;
      else idle = 0;
      n_checks++; if (idle > 3) begin n_fail++; $display("FAIL rnd_starve cyc %0d idle %0d want <=3", c, idle); idle = 0; end
      if (rv) exp_pc = redirect_pc & 16'hFFFE;
      hold_pending = instr_valid && !instr_ready && !rv;
      hold_dat = instr_out;
      hold_pc = instr_pc_out;
      after_redirect = rv;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
